// File: rtl/prf_pkg.sv
// Shared physical-register-file sizing used by the rename, free-list, issue and ready-table blocks.
package prf_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_WB    = 2;
  localparam int NUM_READ  = 4;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/prf_ready_table_if.sv
// Rename/writeback/dispatch signal bundle for the ready-bit table.
interface prf_ready_table_if
  import prf_pkg::*;
#(
  parameter int NUM_PREGS = prf_pkg::NUM_PREGS,
  parameter int NUM_WB    = prf_pkg::NUM_WB,
  parameter int NUM_READ  = prf_pkg::NUM_READ
);
  localparam int PREG_W = $clog2(NUM_PREGS);

  logic                               flush;
  logic                               alloc_valid;
  logic [PREG_W-1:0]                  alloc_preg;
  logic [NUM_WB-1:0]                  wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0]      wb_preg;
  logic [NUM_READ-1:0][PREG_W-1:0]    rd_preg;
  logic [NUM_READ-1:0]                rd_ready;
  logic [PREG_W:0]                    pending_count;

  modport master (
    output flush, alloc_valid, alloc_preg, wb_valid, wb_preg, rd_preg,
    input  rd_ready, pending_count
  );

  modport slave (
    input  flush, alloc_valid, alloc_preg, wb_valid, wb_preg, rd_preg,
    output rd_ready, pending_count
  );
endinterface

// File: rtl/ready_bit.sv
// One ready flag: reset/flush force ready, a clear beats a same-cycle set.
module ready_bit (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic clr,
  input  logic set,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset || flush) q <= 1'b1;
    else if (clr)       q <= 1'b0;
    else if (set)       q <= 1'b1;
  end
endmodule

// File: rtl/prf_ready_table.sv
// Per-physical-register ready table: alloc clears, writeback sets, bypassed dispatch reads,
// registered count of pending registers.
module prf_ready_table
  import prf_pkg::*;
#(
  parameter int NUM_PREGS = prf_pkg::NUM_PREGS,
  parameter int NUM_WB    = prf_pkg::NUM_WB,
  parameter int NUM_READ  = prf_pkg::NUM_READ
) (
  input  logic clk,
  input  logic reset,
  prf_ready_table_if.slave bus
);
  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam logic [PREG_W:0] CNT_ONE = 1;

  logic [NUM_PREGS-1:0] ready;
  logic [NUM_PREGS-1:0] clr;
  logic [NUM_PREGS-1:0] set;
  logic [NUM_PREGS-1:0] ready_nxt;
  logic [NUM_READ-1:0]  rd_ready_c;
  logic [PREG_W:0]      pending_count_p1;

  function automatic logic [PREG_W:0] count_zeros(input logic [NUM_PREGS-1:0] v);
    logic [PREG_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      if (!v[i]) cnt = cnt + CNT_ONE;
    end
    return cnt;
  endfunction

  // Alloc / writeback decoders; preg 0 never clears
  always_comb begin
    clr = '0;
    set = '0;
    for (int i = 1; i < NUM_PREGS; i++) begin
      clr[i] = bus.alloc_valid && (bus.alloc_preg == PREG_W'(i));
      for (int j = 0; j < NUM_WB; j++) begin
        if (bus.wb_valid[j] && (bus.wb_preg[j] == PREG_W'(i))) set[i] = 1'b1;
      end
    end
  end

  assign ready[0] = 1'b1;

  for (genvar g = 1; g < NUM_PREGS; g++) begin : g_bit
    ready_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .flush (bus.flush),
      .clr   (clr[g]),
      .set   (set[g]),
      .q     (ready[g])
    );
  end

  // Next-state image of the table, mirrored so the count tracks the table with no lag
  always_comb begin
    ready_nxt = ready;
    for (int i = 1; i < NUM_PREGS; i++) begin
      if (clr[i])      ready_nxt[i] = 1'b0;
      else if (set[i]) ready_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) pending_count_p1 <= '0;
    else                    pending_count_p1 <= count_zeros(ready_nxt);
  end

  // Read ports: table lookup plus same-cycle writeback bypass; alloc is not yet visible
  always_comb begin
    rd_ready_c = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_ready_c[k] = ready[bus.rd_preg[k]];
      if (!reset && !bus.flush) begin
        for (int j = 0; j < NUM_WB; j++) begin
          if (bus.wb_valid[j] && (bus.wb_preg[j] == bus.rd_preg[k])) rd_ready_c[k] = 1'b1;
        end
      end
    end
  end

  assign bus.rd_ready      = rd_ready_c;
  assign bus.pending_count = pending_count_p1;
endmodule

// File: tb/tb_prf_ready_table.sv
// Directed bench for prf_ready_table with hand-computed expected values.
module tb_prf_ready_table;
  import prf_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  prf_ready_table_if bus ();

  prf_ready_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_preg  = '0;
    bus.wb_valid    = '0;
    bus.wb_preg     = '0;
  endtask

  task automatic set_reads(input int a, input int b, input int c, input int d);
    bus.rd_preg[0] = PREG_W'(a);
    bus.rd_preg[1] = PREG_W'(b);
    bus.rd_preg[2] = PREG_W'(c);
    bus.rd_preg[3] = PREG_W'(d);
    #1;
  endtask

  task automatic alloc(input int p);
    bus.alloc_valid = 1'b1;
    bus.alloc_preg  = PREG_W'(p);
    tick();
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    bus.rd_preg = '0;
    tick();
    tick();
    reset = 1'b0;

    // Out of reset: everything ready, nothing pending
    set_reads(0, 5, 63, 1);
    check("reset_rd", {28'd0, bus.rd_ready}, 32'hF);
    check("reset_cnt", {25'd0, bus.pending_count}, 0);

    alloc(5);
    set_reads(5, 0, 0, 0);
    check("alloc5_rd", {31'd0, bus.rd_ready[0]}, 0);
    check("alloc5_cnt", {25'd0, bus.pending_count}, 1);
    alloc(9);
    set_reads(5, 9, 6, 0);
    check("alloc9_rd", {28'd0, bus.rd_ready}, 32'b1100);
    check("alloc9_cnt", {25'd0, bus.pending_count}, 2);

    // Writeback of 5 bypasses in the same cycle
    bus.wb_valid[0] = 1'b1;
    bus.wb_preg[0]  = PREG_W'(5);
    set_reads(5, 9, 0, 0);
    check("wb5_bypass", {28'd0, bus.rd_ready}, 32'b1101);
    tick();
    idle();
    set_reads(5, 9, 0, 0);
    check("wb5_after", {28'd0, bus.rd_ready}, 32'b1101);
    check("wb5_cnt", {25'd0, bus.pending_count}, 1);

    // Alloc and wb of 7 together: read sees 1, table ends 0
    bus.alloc_valid = 1'b1;
    bus.alloc_preg  = PREG_W'(7);
    bus.wb_valid[1] = 1'b1;
    bus.wb_preg[1]  = PREG_W'(7);
    set_reads(7, 0, 0, 0);
    check("aw7_same", {31'd0, bus.rd_ready[0]}, 1);
    tick();
    idle();
    set_reads(7, 0, 0, 0);
    check("aw7_after", {31'd0, bus.rd_ready[0]}, 0);
    check("aw7_cnt", {25'd0, bus.pending_count}, 2);

    alloc(0);
    set_reads(0, 0, 0, 0);
    check("alloc0_rd", {31'd0, bus.rd_ready[0]}, 1);
    check("alloc0_cnt", {25'd0, bus.pending_count}, 2);

    // Duplicate writeback of 9 on both ports
    bus.wb_valid = 2'b11;
    bus.wb_preg[0] = PREG_W'(9);
    bus.wb_preg[1] = PREG_W'(9);
    tick();
    idle();
    set_reads(9, 7, 0, 0);
    check("dupwb_rd", {28'd0, bus.rd_ready}, 32'b1101);
    check("dupwb_cnt", {25'd0, bus.pending_count}, 1);

    // Fill 1..63, then flush with a concurrent alloc 12 and wb 3
    for (int i = 1; i < NUM_PREGS; i++) begin
      alloc(i);
      if (i == 32) check("fill32_cnt", {25'd0, bus.pending_count}, 32);
    end
    check("fill_cnt", {25'd0, bus.pending_count}, 63);
    bus.flush       = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_preg  = PREG_W'(12);
    bus.wb_valid[0] = 1'b1;
    bus.wb_preg[0]  = PREG_W'(3);
    set_reads(3, 0, 0, 0);
    check("flush_nobypass", {31'd0, bus.rd_ready[0]}, 0);
    tick();
    idle();
    set_reads(12, 3, 63, 1);
    check("flush_rd", {28'd0, bus.rd_ready}, 32'hF);
    check("flush_cnt", {25'd0, bus.pending_count}, 0);

    // Same again, reset mid-operation instead of flush
    for (int i = 1; i < NUM_PREGS; i++) alloc(i);
    check("fill2_cnt", {25'd0, bus.pending_count}, 63);
    reset           = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_preg  = PREG_W'(12);
    bus.wb_valid[0] = 1'b1;
    bus.wb_preg[0]  = PREG_W'(3);
    set_reads(3, 0, 0, 0);
    check("reset_nobypass", {31'd0, bus.rd_ready[0]}, 0);
    tick();
    reset = 1'b0;
    idle();
    set_reads(12, 3, 63, 1);
    check("midreset_rd", {28'd0, bus.rd_ready}, 32'hF);
    check("midreset_cnt", {25'd0, bus.pending_count}, 0);

    // Writeback to a ready register, double alloc to a pending one
    bus.wb_valid[1] = 1'b1;
    bus.wb_preg[1]  = PREG_W'(40);
    tick();
    idle();
    check("wbready_cnt", {25'd0, bus.pending_count}, 0);
    alloc(30);
    alloc(30);
    set_reads(30, 40, 0, 0);
    check("dupalloc_rd", {28'd0, bus.rd_ready}, 32'b1110);
    check("dupalloc_cnt", {25'd0, bus.pending_count}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
